aes_256_word_loader: RTL and testbench

AES_256_WORD_LOADER -- requirements
Module: aes_256_word_loader

---
 rtl/aes_256_word_loader.sv | 120 ++++++++++++
 tb/tb_aes_256_word_loader.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_256_word_loader.sv
// Word-serial loader around a combinational AES-256 core: 32-bit key/block words in, 128-bit ciphertext out.
// Optional AES_LOADER_KEY_GUARD_EN: refuse block words until one complete 8-word key load has been seen.
module aes_256_word_loader #(
   parameter int unsigned CALC_CYCLES = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         in_is_key,
   input  logic [31:0]  in_data,
   output logic [255:0] core_key,
   output logic [127:0] core_state,
   input  logic [127:0] core_out,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data
);

   typedef enum logic [1:0] {LOAD, CALC, DONE} state_t;

   localparam logic [3:0] CALC_INIT = 4'(CALC_CYCLES - 1);

   state_t      state_q;
   state_t      state_d;
   logic [2:0]  key_cnt;
   logic [1:0]  blk_cnt;
   logic [3:0]  calc_cnt;
   logic        key_loaded;
   logic        blk_allow;
   logic        key_acc;
   logic        blk_acc;
   logic        blk_last;
   logic        capture;
   logic        release_out;

`ifdef AES_LOADER_KEY_GUARD_EN
   assign blk_allow = key_loaded;
`else
   assign blk_allow = 1'b1;
`endif

   // Key and block loads never interleave: whichever stream has started owns the port until it completes.
   always_comb begin
      in_ready = 1'b0;
      if (state_q == LOAD) begin
         if (in_is_key)
            in_ready = (blk_cnt == 2'd0);
         else
            in_ready = (key_cnt == 3'd0) && blk_allow;
      end
   end

   assign key_acc     = in_valid && in_ready && in_is_key;
   assign blk_acc     = in_valid && in_ready && !in_is_key;
   assign blk_last    = blk_acc && (blk_cnt == 2'd3);
   assign capture     = (state_q == CALC) && (calc_cnt == 4'd0);
   assign release_out = (state_q == DONE) && out_ready;

   always_comb begin
      state_d = state_q;
      case (state_q)
         LOAD:    if (blk_last)    state_d = CALC;
         CALC:    if (capture)     state_d = DONE;
         DONE:    if (release_out) state_d = LOAD;
         default:                  state_d = LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         state_q <= LOAD;
      else
         state_q <= state_d;
   end

   // Input shift registers; they only move in LOAD, so the core sees stable operands through CALC.
   always_ff @(posedge clk) begin
      if (rst) begin
         core_key   <= '0;
         core_state <= '0;
         key_cnt    <= '0;
         blk_cnt    <= '0;
         key_loaded <= 1'b0;
      end else begin
         if (key_acc) begin
            core_key <= {core_key[223:0], in_data};
            key_cnt  <= key_cnt + 3'd1;
            if (key_cnt == 3'd7)
               key_loaded <= 1'b1;
         end
         if (blk_acc) begin
            core_state <= {core_state[95:0], in_data};
            blk_cnt    <= blk_cnt + 2'd1;
         end
      end
   end

   // Settle counter and ciphertext capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         calc_cnt  <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
      end else begin
         if (blk_last)
            calc_cnt <= CALC_INIT;
         else if ((state_q == CALC) && (calc_cnt != 4'd0))
            calc_cnt <= calc_cnt - 4'd1;

         if (capture) begin
            out_data  <= core_out;
            out_valid <= 1'b1;
         end else if (release_out) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_aes_256_word_loader.sv
// Directed bench for aes_256_word_loader; the AES core is stood in by a lookup for the FIPS-197 C.3 vector
// plus a simple keyed mixing function for other operands. Covers AES_LOADER_KEY_GUARD_EN when defined.
module tb_aes_256_word_loader;

   localparam int CC = 4;

   localparam logic [255:0] FIPS_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [255:0] KEY2     = 256'h11111111_22222222_33333333_44444444_55555555_66666666_77777777_88888888;
   localparam logic [127:0] PT2      = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
   localparam logic [127:0] CT2      = 128'h43424140_47464544_4b4a4948_c7c6c5c4;
   localparam logic [127:0] PT0      = 128'h0123456789abcdef_fedcba9876543210;
   localparam logic [127:0] CT0      = 128'hfedcba9876543210_0123456789abcdef;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic         in_is_key;
   logic [31:0]  in_data;
   logic [255:0] core_key;
   logic [127:0] core_state;
   logic [127:0] core_out;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;

   int n_chk  = 0;
   int n_pass = 0;

   aes_256_word_loader #(.CALC_CYCLES(CC)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_is_key  (in_is_key),
      .in_data    (in_data),
      .core_key   (core_key),
      .core_state (core_state),
      .core_out   (core_out),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] core_fn(input logic [255:0] k, input logic [127:0] s);
      if (k == FIPS_KEY && s == FIPS_PT)
         return FIPS_CT;
      return {s[63:0], s[127:64]} ^ k[255:128] ^ k[127:0];
   endfunction

   assign core_out = core_fn(core_key, core_state);

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_chk++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic is_key, input logic [31:0] d, input string tag);
      in_valid  = 1'b1;
      in_is_key = is_key;
      in_data   = d;
      #1;
      chk(tag, 256'(in_ready), 256'd1);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic send_key(input logic [255:0] k, input int first, input int last);
      for (int i = first; i <= last; i++)
         send(1'b1, k[255 - 32*i -: 32], "key_word_ready");
   endtask

   task automatic send_blk(input logic [127:0] p, input int first, input int last);
      for (int i = first; i <= last; i++)
         send(1'b0, p[127 - 32*i -: 32], "blk_word_ready");
   endtask

   // Called just after the 4th block-word handshake edge.
   task automatic wait_result(input logic [127:0] exp, input string tag);
      chk({tag, "_calc_in_ready"}, 256'(in_ready), 256'd0);
      chk({tag, "_early_valid"}, 256'(out_valid), 256'd0);
      for (int i = 1; i < CC; i++) begin
         tick();
         chk({tag, "_early_valid"}, 256'(out_valid), 256'd0);
      end
      tick();
      chk({tag, "_valid"}, 256'(out_valid), 256'd1);
      chk({tag, "_data"}, 256'(out_data), 256'(exp));
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("release_valid", 256'(out_valid), 256'd0);
      in_is_key = 1'b1;
      #1;
      chk("release_in_ready", 256'(in_ready), 256'd1);
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_is_key = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      repeat (3) tick();
      rst = 1'b0;

      chk("rst_out_valid", 256'(out_valid), 256'd0);
      in_is_key = 1'b1;
      #1;
      chk("rst_in_ready_key", 256'(in_ready), 256'd1);
      chk("rst_core_key", core_key, 256'd0);
      chk("rst_core_state", 256'(core_state), 256'd0);
      chk("rst_out_data", 256'(out_data), 256'd0);

`ifdef AES_LOADER_KEY_GUARD_EN
      in_is_key = 1'b0;
      in_data   = 32'h00112233;
      #1;
      chk("guard_no_key", 256'(in_ready), 256'd0);
      send_key(FIPS_KEY, 0, 6);
      in_is_key = 1'b0;
      #1;
      chk("guard_7_words", 256'(in_ready), 256'd0);
      send_key(FIPS_KEY, 7, 7);
      in_is_key = 1'b0;
      #1;
      chk("guard_8_words", 256'(in_ready), 256'd1);
`else
      in_is_key = 1'b0;
      #1;
      chk("nokey_blk_ready", 256'(in_ready), 256'd1);
      send_blk(PT0, 0, 3);
      wait_result(CT0, "zero_key");
      release_out();
      send_key(FIPS_KEY, 0, 7);
`endif
      chk("fips_core_key", core_key, FIPS_KEY);

      send_blk(FIPS_PT, 0, 3);
      chk("fips_core_state", 256'(core_state), 256'(FIPS_PT));
      wait_result(FIPS_CT, "fips");

      // Backpressure with words offered on the input during DONE.
      in_valid = 1'b1;
      in_data  = 32'hdeadbeef;
      for (int i = 0; i < 10; i++) begin
         in_is_key = i[0];
         #1;
         chk("bp_valid", 256'(out_valid), 256'd1);
         chk("bp_data", 256'(out_data), 256'(FIPS_CT));
         chk("bp_in_ready", 256'(in_ready), 256'd0);
         tick();
      end
      in_is_key = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("done_ready_in_ready", 256'(in_ready), 256'd0);
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("done_exit_valid", 256'(out_valid), 256'd0);
      chk("done_key_untouched", core_key, FIPS_KEY);
      #1;
      chk("done_exit_in_ready", 256'(in_ready), 256'd1);

      // Key reuse, with a key word offered mid-block.
      send_blk(FIPS_PT, 0, 1);
      in_valid  = 1'b1;
      in_is_key = 1'b1;
      in_data   = 32'hcafef00d;
      #1;
      chk("interleave_key_ready", 256'(in_ready), 256'd0);
      tick();
      in_valid = 1'b0;
      chk("interleave_key_kept", core_key, FIPS_KEY);
      send_blk(FIPS_PT, 2, 3);
      wait_result(FIPS_CT, "reuse");
      release_out();

      // Partial key load blocks block words and shows a partially shifted key.
      send_key(KEY2, 0, 2);
      chk("partial_key", core_key, {FIPS_KEY[159:0], KEY2[255:160]});
      in_is_key = 1'b0;
      #1;
      chk("partial_blk_ready", 256'(in_ready), 256'd0);
      send_key(KEY2, 3, 7);
      chk("key2_core_key", core_key, KEY2);
      send_blk(PT2, 0, 3);
      wait_result(CT2, "key2");
      release_out();

      // Reset while calc_cnt == 2.
      send_blk(PT2, 0, 3);
      tick();
      chk("midcalc_valid", 256'(out_valid), 256'd0);
      rst = 1'b1;
      tick();
      rst       = 1'b0;
      in_is_key = 1'b1;
      chk("midrst_out_valid", 256'(out_valid), 256'd0);
      chk("midrst_core_key", core_key, 256'd0);
      chk("midrst_core_state", 256'(core_state), 256'd0);
      chk("midrst_out_data", 256'(out_data), 256'd0);
      #1;
      chk("midrst_in_ready", 256'(in_ready), 256'd1);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("midrst_no_pulse", 256'(out_valid), 256'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
